// File: rtl/dram_wb_arbiter.sv
// Round-robin two-master Wishbone arbiter (CPU = master 0, DMA = master 1) in front of the
// user-area DRAM slave. It caps DMA bursts while the CPU waits and aborts cycles that never get an ack.
module dram_wb_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_MAX  = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_we_i,
  input  logic [3:0]            m0_sel_i,
  input  logic [ADDR_WIDTH-1:0] m0_adr_i,
  input  logic [DATA_WIDTH-1:0] m0_dat_i,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  output logic [DATA_WIDTH-1:0] m0_dat_o,
  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_adr_i,
  input  logic [DATA_WIDTH-1:0] m1_dat_i,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic [DATA_WIDTH-1:0] m1_dat_o,
  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [3:0]            s_sel_o,
  output logic [ADDR_WIDTH-1:0] s_adr_o,
  output logic [DATA_WIDTH-1:0] s_dat_o,
  input  logic [DATA_WIDTH-1:0] s_dat_i,
  input  logic                  s_ack_i,
  output logic [1:0]            grant_o
);

  localparam int BW = $clog2(BURST_MAX + 1);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, GNT_CPU, GNT_DMA, ABORT} state_t;

  state_t          state;
  logic            last_owner_dma;
  logic [BW-1:0]   beat_cnt;
  logic [TW-1:0]   to_cnt;

  logic req0, req1, owner_cyc, slv_stb, ack_v, timeout_hit, cap_hit;

  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;

  // last_owner_dma is updated on grant entry, so it also names the owner while in ABORT
  assign owner_cyc   = last_owner_dma ? m1_cyc_i : m0_cyc_i;
  assign slv_stb     = ((state == GNT_CPU) & req0) | ((state == GNT_DMA) & req1);
  assign ack_v       = slv_stb & s_ack_i;
  assign timeout_hit = slv_stb & ~s_ack_i & (to_cnt == TW'(TIMEOUT - 1));
  assign cap_hit     = (state == GNT_DMA) & ack_v & req0 & (beat_cnt >= BW'(BURST_MAX - 1));

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state          <= IDLE;
      last_owner_dma <= 1'b1;
      beat_cnt       <= '0;
      to_cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          beat_cnt <= '0;
          to_cnt   <= '0;
          if (req0 && (!req1 || last_owner_dma)) begin
            state          <= GNT_CPU;
            last_owner_dma <= 1'b0;
          end else if (req1) begin
            state          <= GNT_DMA;
            last_owner_dma <= 1'b1;
          end
        end
        GNT_CPU, GNT_DMA: begin
          if (ack_v) begin
            to_cnt <= '0;
            // saturate so an uncapped long burst cannot wrap back below the cap
            if ((state == GNT_DMA) && (beat_cnt != BW'(BURST_MAX)))
              beat_cnt <= beat_cnt + 1'b1;
          end else if (slv_stb) begin
            to_cnt <= to_cnt + 1'b1;
          end
          if (!owner_cyc)
            state <= IDLE;
          else if (timeout_hit)
            state <= ABORT;
          else if (cap_hit)
            state <= IDLE;
        end
        ABORT: begin
          if (!owner_cyc)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = 4'h0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_dat_o = '0;
    grant_o  = 2'b00;
    case (state)
      GNT_CPU: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = slv_stb;
        s_we_o   = m0_we_i;
        s_sel_o  = m0_sel_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        m0_ack_o = ack_v;
        m0_err_o = timeout_hit;
        m0_dat_o = s_dat_i;
        grant_o  = 2'b01;
      end
      GNT_DMA: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = slv_stb;
        s_we_o   = m1_we_i;
        s_sel_o  = 4'hF;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        m1_ack_o = ack_v;
        m1_err_o = timeout_hit;
        m1_dat_o = s_dat_i;
        grant_o  = 2'b10;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dram_wb_arbiter.sv
// Bench for dram_wb_arbiter: behavioural DRAM slave, directed CPU/DMA masters and a
// scoreboard monitor that matches every master ack against queued expected read data.
module tb_dram_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_cyc = 0, m0_stb = 0, m0_we = 0;
  logic [3:0]  m0_sel = 0;
  logic [31:0] m0_adr = 0, m0_dat = 0;
  logic        m1_cyc = 0, m1_stb = 0, m1_we = 0;
  logic [31:0] m1_adr = 0, m1_dat = 0;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        s_cyc_o, s_stb_o, s_we_o, s_ack_i;
  logic [3:0]  s_sel_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic [1:0]  grant_o;

  dram_wb_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BURST_MAX(16), .TIMEOUT(255)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m0_dat_o(m0_dat_o),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .m1_dat_o(m1_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .grant_o(grant_o)
  );

  always #5 clk = ~clk;

  // Slave: acks once stb has been held slave_lat cycles; read data is a fixed function of address
  int   slave_lat  = 0;
  logic slave_mute = 1'b0;
  int   wait_cnt;
  assign s_ack_i = s_cyc_o & s_stb_o & ~slave_mute & (wait_cnt >= slave_lat);
  assign s_dat_i = s_adr_o ^ 32'hDEADBEEF;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_cnt <= 0;
    else if (s_cyc_o && s_stb_o && !s_ack_i) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  int n_checks = 0, n_err = 0;
  logic [31:0] cpu_q[$];
  logic [31:0] dma_q[$];
  int m0_acks, m1_acks, m0_errs, m1_errs, dma_grants, m1_at_cpu, dma_beats;
  logic [1:0] prev_grant, first_grant;
  logic dma_kill = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: got timeout/unexpected event expected none", name);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (m0_ack_o) begin
      if (cpu_q.size() == 0) fail_now("m0_ack_unexpected");
      else check("m0_dat_o", m0_dat_o, cpu_q.pop_front());
      if (m1_at_cpu < 0) m1_at_cpu = m1_acks;
      m0_acks++;
    end
    if (m1_ack_o) begin
      if (dma_q.size() == 0) fail_now("m1_ack_unexpected");
      else check("m1_dat_o", m1_dat_o, dma_q.pop_front());
      m1_acks++;
    end
    if (m0_err_o) m0_errs++;
    if (m1_err_o) m1_errs++;
    if (grant_o == 2'b10 && prev_grant != 2'b10) dma_grants++;
    if (first_grant == 2'b00 && grant_o != 2'b00) first_grant = grant_o;
    prev_grant = grant_o;
  end

  task automatic clear_stats();
    m0_acks = 0; m1_acks = 0; m0_errs = 0; m1_errs = 0;
    dma_grants = 0; m1_at_cpu = -1; dma_beats = 0; first_grant = 2'b00;
  endtask

  task automatic cpu_start(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                           input logic [31:0] dat, input logic [31:0] exp, input logic exp_ack);
    m0_adr = adr; m0_we = we; m0_sel = sel; m0_dat = dat;
    m0_cyc = 1'b1; m0_stb = 1'b1;
    if (exp_ack) cpu_q.push_back(exp);
  endtask

  task automatic wait_m0(input int limit, output int n, output logic err);
    logic done = 1'b0;
    n = 0; err = 1'b0;
    while (!done && n < limit) begin
      @(negedge clk);
      n++;
      if (m0_ack_o || m0_err_o) begin done = 1'b1; err = m0_err_o; end
    end
    if (!done) fail_now("m0_wait_timeout");
  endtask

  task automatic cpu_stop();
    @(posedge clk); #1;
    m0_cyc = 1'b0; m0_stb = 1'b0;
  endtask

  task automatic cpu_xfer(input logic [31:0] adr, input logic [31:0] exp);
    int n; logic e;
    cpu_start(adr, 1'b0, 4'hF, 32'h0, exp, 1'b1);
    wait_m0(2000, n, e);
    cpu_stop();
  endtask

  task automatic dma_burst(input logic [31:0] base, input int beats, output int nwait, output int acked);
    logic got, bad;
    int t;
    nwait = 0; acked = 0; bad = 1'b0;
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b0;
    for (int i = 0; i < beats && !dma_kill && !bad; i++) begin
      m1_adr = base + 32'(4 * i);
      m1_dat = ~m1_adr;
      dma_q.push_back((base + 32'(4 * i)) ^ 32'hDEADBEEF);
      got = 1'b0; t = 0;
      while (!got && !dma_kill && t < 2000) begin
        @(negedge clk);
        t++; nwait++;
        if (m1_ack_o) got = 1'b1;
      end
      if (got) begin
        acked++;
        dma_beats = acked;
        @(posedge clk); #1;
      end else if (!dma_kill) begin
        fail_now("m1_ack_timeout");
        bad = 1'b1;
      end
    end
    m1_cyc = 1'b0; m1_stb = 1'b0;
  endtask

  task automatic wait_beats(input int k);
    int t = 0;
    while (dma_beats < k && t < 500) begin @(negedge clk); t++; end
    if (dma_beats < k) fail_now("dma_beats_wait");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, nw, acked, t;
    logic e;
    clear_stats();
    prev_grant = 2'b00;

    // Reset state
    @(negedge clk);
    check("rst_ctrl", {29'd0, s_cyc_o, s_stb_o, m0_ack_o}, 32'd0);
    check("rst_grant", {30'd0, grant_o}, 32'd0);
    check("rst_dat", m0_dat_o | m1_dat_o | s_adr_o, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Test 1: single CPU read, slave latency 2
    clear_stats();
    slave_lat = 2;
    cpu_start(32'h0, 1'b0, 4'h3, 32'h0, 32'hDEADBEEF, 1'b1);
    @(negedge clk);
    check("t1_scyc_before_grant", {31'd0, s_cyc_o}, 32'd0);
    @(negedge clk);
    check("t1_scyc_granted", {31'd0, s_cyc_o}, 32'd1);
    check("t1_grant", {30'd0, grant_o}, 32'd1);
    check("t1_sel", {28'd0, s_sel_o}, 32'h3);
    wait_m0(20, n, e);
    check("t1_ack_latency", 32'(n), 32'd2);
    cpu_stop();
    @(negedge clk);
    check("t1_ack_one_clk", {31'd0, m0_ack_o}, 32'd0);
    check("t1_m0_acks", 32'(m0_acks), 32'd1);
    check("t1_m1_acks", 32'(m1_acks), 32'd0);
    @(posedge clk); #1;

    // Test 2: simultaneous request after reset -> CPU first, idle clk, then DMA
    rst_n = 1'b0; #1; rst_n = 1'b1;
    clear_stats();
    slave_lat = 1;
    @(posedge clk); #1;
    fork
      cpu_xfer(32'h100, 32'hDEADBFEF);
      dma_burst(32'h1000, 2, nw, acked);
      begin
        t = 0;
        do begin @(negedge clk); t++; end while (grant_o == 2'b00 && t < 20);
        check("t2_first_grant", {30'd0, grant_o}, 32'd1);
        t = 0;
        do begin @(negedge clk); t++; end while (grant_o == 2'b01 && t < 50);
        check("t2_idle_gap", {30'd0, grant_o}, 32'd0);
        @(negedge clk);
        check("t2_dma_grant", {30'd0, grant_o}, 32'd2);
        check("t2_dma_sel", {28'd0, s_sel_o}, 32'hF);
      end
    join
    check("t2_dma_acked", 32'(acked), 32'd2);
    @(posedge clk); #1;

    // Test 3: 40-beat DMA burst, CPU requests from beat 3 -> burst capped at 16
    clear_stats();
    slave_lat = 0;
    fork
      dma_burst(32'h2000, 40, nw, acked);
      begin
        wait_beats(3);
        @(posedge clk); #1;
        cpu_xfer(32'h300, 32'hDEADBDEF);
      end
    join
    check("t3_dma_acked", 32'(acked), 32'd40);
    check("t3_acks_before_cpu", 32'(m1_at_cpu), 32'd16);
    check("t3_dma_grants", 32'(dma_grants), 32'd2);
    check("t3_cpu_acks", 32'(m0_acks), 32'd1);
    @(posedge clk); #1;

    // Test 4: 40-beat DMA burst alone -> consecutive acks on one grant
    clear_stats();
    dma_burst(32'h4000, 40, nw, acked);
    check("t4_dma_acked", 32'(acked), 32'd40);
    check("t4_cycles", 32'(nw), 32'd41);
    check("t4_dma_grants", 32'(dma_grants), 32'd1);
    @(posedge clk); #1;

    // Test 5: slave never acks a CPU write -> err after TIMEOUT-1 stalled clocks
    clear_stats();
    slave_mute = 1'b1;
    cpu_start(32'h200, 1'b1, 4'hF, 32'hCAFE0001, 32'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("t5_we", {31'd0, s_we_o}, 32'd1);
    check("t5_wdat", s_dat_o, 32'hCAFE0001);
    wait_m0(400, n, e);
    check("t5_err_latency", 32'(n), 32'd254);
    check("t5_err_flag", {31'd0, e}, 32'd1);
    check("t5_no_ack", {31'd0, m0_ack_o}, 32'd0);
    @(negedge clk);
    check("t5_scyc_dropped", {30'd0, s_cyc_o, s_stb_o}, 32'd0);
    check("t5_err_pulse", {31'd0, m0_err_o}, 32'd0);
    cpu_stop();
    slave_mute = 1'b0;
    dma_burst(32'h5000, 2, nw, acked);
    check("t5_dma_after_abort", 32'(acked), 32'd2);
    check("t5_err_count", 32'(m0_errs), 32'd1);
    check("t5_m0_acks", 32'(m0_acks), 32'd0);
    @(posedge clk); #1;

    // Test 6: asynchronous reset mid DMA burst
    clear_stats();
    fork
      dma_burst(32'h6000, 40, nw, acked);
      begin
        wait_beats(10);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_ctrl", {26'd0, s_cyc_o, s_stb_o, m1_ack_o, m1_err_o, grant_o}, 32'd0);
        check("t6_rst_data", s_adr_o | m1_dat_o, 32'd0);
        dma_kill = 1'b1;
      end
    join
    dma_q.delete();
    dma_kill = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t6_held_idle", {30'd0, grant_o}, 32'd0);
    rst_n = 1'b1;
    clear_stats();
    @(posedge clk); #1;
    fork
      cpu_xfer(32'h700, 32'hDEADB9EF);
      dma_burst(32'h7000, 2, nw, acked);
    join
    check("t6_first_grant", {30'd0, first_grant}, 32'd1);
    check("t6_dma_acked", 32'(acked), 32'd2);
    check("t6_dma_errs", 32'(m1_errs), 32'd0);
    check("end_queues", 32'(cpu_q.size() + dma_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
